// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage load/store unit.
// Turns one load/store per instruction into a req/gnt/rvalid bus transaction,
// places store bytes on the right lanes, extends load data and rejects
// misaligned accesses. The pipeline is stalled while a transaction is open.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   mem_ctrl           MemRW (none/read/write) + RWType (funct3 size code)
//   valid, flush, hold MEM-stage valid, kill, downstream stall
//   addr, wdata        effective address, store data
//   stall              freeze IF..MEM until the access completes
//   rdata              extended load result (valid in DONE)
//   misaligned         1-cycle pulse, access rejected
//   bus_err            1-cycle pulse, timeout expired, access abandoned
//   dbus_*             data bus request side (req/we/addr/wdata/be) and
//                      response side (gnt/rvalid/rdata)

package mem_access_pkg;
  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_rw_e;

  typedef struct packed {
    mem_rw_e    MemRW;
    logic [2:0] RWType;
  } mem_control_t;
endpackage

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  mem_control_t mem_ctrl,
  input  logic         valid,
  input  logic         flush,
  input  logic         hold,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output logic         stall,
  output logic [31:0]  rdata,
  output logic         misaligned,
  output logic         bus_err,
  output logic         dbus_req,
  output logic         dbus_we,
  output logic [31:0]  dbus_addr,
  output logic [31:0]  dbus_wdata,
  output logic [3:0]   dbus_be,
  input  logic         dbus_gnt,
  input  logic         dbus_rvalid,
  input  logic [31:0]  dbus_rdata
);

  // Counter only has to reach TIMEOUT-1: the timeout fires during that cycle.
  localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          we_q, we_d;
  logic          kill_q, kill_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          access;
  logic          bad_align;
  logic          timeout_hit;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_ext;

  assign access = valid & ~flush & (mem_ctrl.MemRW != MEM_NONE);

  always_comb begin
    bad_align = 1'b0;
    case (mem_ctrl.RWType)
      3'b011, 3'b110, 3'b111: bad_align = 1'b1;
      3'b001, 3'b101:         bad_align = addr[0];
      3'b010:                 bad_align = |addr[1:0];
      default:                bad_align = 1'b0;
    endcase
  end

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // Load extraction from the returned word, using the latched offset/size.
  assign rd_shift = dbus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    rd_ext = rd_shift;
    case (size_q)
      2'b00:   rd_ext = uns_q ? {24'h0, rd_shift[7:0]}
                              : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = uns_q ? {16'h0, rd_shift[15:0]}
                              : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Bus outputs come from latched state only, so they cannot move before gnt.
  always_comb begin
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = '0;
    dbus_wdata = '0;
    dbus_be    = '0;
    if (state_q == S_REQ) begin
      dbus_req  = 1'b1;
      dbus_we   = we_q;
      dbus_addr = {addr_q[31:2], 2'b00};
      dbus_be   = 4'hF;
      if (we_q) begin
        case (size_q)
          2'b00: begin
            dbus_be    = 4'b0001 << addr_q[1:0];
            dbus_wdata = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            dbus_be    = 4'b0011 << addr_q[1:0];
            dbus_wdata = {2{wdata_q[15:0]}};
          end
          default: dbus_wdata = wdata_q;
        endcase
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    kill_d     = kill_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    stall      = 1'b0;
    misaligned = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (bad_align) begin
            misaligned = 1'b1;
          end else begin
            stall   = 1'b1;
            addr_d  = addr;
            wdata_d = wdata;
            size_d  = mem_ctrl.RWType[1:0];
            uns_d   = mem_ctrl.RWType[2];
            we_d    = (mem_ctrl.MemRW == MEM_WRITE);
            kill_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        // A granted read cannot be withdrawn; a flush alongside gnt is
        // remembered and the response is awaited then dropped.
        if (dbus_gnt) begin
          if (we_q) begin
            state_d = flush ? S_IDLE : S_DONE;
          end else begin
            kill_d  = flush;
            state_d = S_WAIT;
          end
        end else if (flush) begin
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end
      end

      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (flush) kill_d = 1'b1;
        if (dbus_rvalid) begin
          if (kill_q | flush) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = rd_ext;
            state_d = S_DONE;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
          if (kill_q | flush) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = '0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (!hold) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdata   = rdata_q;
  assign bus_err = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  mem_control_t mem_ctrl;
  logic         valid, flush, hold;
  logic [31:0]  addr, wdata;
  logic         dbus_gnt, dbus_rvalid;
  logic [31:0]  dbus_rdata;

  logic         stall, misaligned, bus_err, dbus_req, dbus_we;
  logic [31:0]  rdata, dbus_addr, dbus_wdata;
  logic [3:0]   dbus_be;

  logic         stall_t, misaligned_t, bus_err_t, dbus_req_t, dbus_we_t;
  logic [31:0]  rdata_t, dbus_addr_t, dbus_wdata_t;
  logic [3:0]   dbus_be_t;

  int unsigned  n_chk  = 0;
  int unsigned  n_pass = 0;
  logic [31:0]  last_rd;
  logic [31:0]  got;

  always #5 clk = ~clk;

  mem_access_unit u_dut (
    .clk(clk), .rst_n(rst_n), .mem_ctrl(mem_ctrl), .valid(valid),
    .flush(flush), .hold(hold), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  mem_access_unit #(.TIMEOUT(4)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .mem_ctrl(mem_ctrl), .valid(valid),
    .flush(flush), .hold(hold), .addr(addr), .wdata(wdata),
    .stall(stall_t), .rdata(rdata_t), .misaligned(misaligned_t), .bus_err(bus_err_t),
    .dbus_req(dbus_req_t), .dbus_we(dbus_we_t), .dbus_addr(dbus_addr_t),
    .dbus_wdata(dbus_wdata_t), .dbus_be(dbus_be_t), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int unsigned o, n;
    if (!we) return 4'hF;
    o = a % 4;
    n = nbytes(f3);
    be = '0;
    for (int unsigned i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + n);
    return be;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] d);
    case (nbytes(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    logic        sgn;
    sgn = (f3 < 3'd4);
    v = w >> (8 * (a % 4));
    case (nbytes(f3))
      1: begin
        v = v & 32'hFF;
        if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      2: begin
        v = v & 32'hFFFF;
        if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; flush = 1'b0; hold = 1'b0;
    mem_ctrl.MemRW = MEM_NONE; mem_ctrl.RWType = 3'b000;
    addr = '0; wdata = '0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    last_rd = '0;
  endtask

  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    valid = 1'b1; flush = 1'b0; hold = 1'b0;
    mem_ctrl.MemRW = we ? MEM_WRITE : MEM_READ;
    mem_ctrl.RWType = f3;
    addr = a; wdata = wd;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
  endtask

  // One complete instruction: gd idle gnt cycles, rd idle rvalid cycles,
  // holdn cycles of downstream hold in DONE. Returns rdata after completion.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int unsigned gd, input int unsigned rd,
                         input logic [31:0] rword, input int unsigned holdn,
                         output logic [31:0] res);
    logic [31:0] exp_rd;
    present(we, f3, a, wd);
    @(negedge clk);
    if (ref_mis(f3, a)) begin
      chk("mis_pulse", 32'(misaligned), 32'd1);
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_req", 32'(dbus_req), 32'd0);
      step();
      valid = 1'b0;
      @(negedge clk);
      chk("mis_clear", 32'(misaligned), 32'd0);
      chk("mis_no_req", 32'(dbus_req), 32'd0);
      step();
      res = rdata;
      return;
    end
    chk("issue_stall", 32'(stall), 32'd1);
    chk("issue_no_req", 32'(dbus_req), 32'd0);
    chk("issue_no_mis", 32'(misaligned), 32'd0);
    for (int unsigned i = 0; i <= gd; i++) begin
      step();
      dbus_gnt = (i == gd);
      @(negedge clk);
      chk("req_stall", 32'(stall), 32'd1);
      chk("req", 32'(dbus_req), 32'd1);
      chk("req_addr", dbus_addr, a & 32'hFFFF_FFFC);
      chk("req_we", 32'(dbus_we), 32'(we));
      chk("req_be", 32'(dbus_be), 32'(ref_be(we, f3, a)));
      if (we) chk("req_wdata", dbus_wdata, ref_wd(f3, wd));
    end
    exp_rd = last_rd;
    if (!we) begin
      exp_rd = ref_load(f3, a, rword);
      for (int unsigned i = 0; i <= rd; i++) begin
        step();
        dbus_gnt = 1'b0;
        dbus_rvalid = (i == rd);
        dbus_rdata = (i == rd) ? rword : $urandom();
        @(negedge clk);
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_no_req", 32'(dbus_req), 32'd0);
      end
      last_rd = exp_rd;
    end
    for (int unsigned h = 0; h <= holdn; h++) begin
      step();
      dbus_gnt = 1'b0;
      dbus_rvalid = 1'b0;
      hold = (h < holdn);
      @(negedge clk);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_no_req", 32'(dbus_req), 32'd0);
      chk("done_no_err", 32'(bus_err), 32'd0);
      chk("done_rdata", rdata, exp_rd);
    end
    step();
    hold = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk("post_stall", 32'(stall), 32'd0);
    chk("post_no_req", 32'(dbus_req), 32'd0);
    res = rdata;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic        we;
    logic [31:0] a;

    do_reset();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_be", 32'(dbus_be), 32'd0);
    chk("rst_addr", dbus_addr, 32'd0);
    chk("rst_wdata", dbus_wdata, 32'd0);
    chk("rst_we", 32'(dbus_we), 32'd0);
    step();

    // Stores
    run_txn(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, got);
    run_txn(1'b1, 3'b000, 32'h103, 32'h0000_0012, 0, 0, 32'h0, 0, got);

    // Loads from 0x80FF7F01
    run_txn(1'b0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80FF_7F01, 0, got);
    chk("LB+3", got, 32'hFFFF_FF80);
    run_txn(1'b0, 3'b100, 32'h201, 32'h0, 0, 0, 32'h80FF_7F01, 0, got);
    chk("LBU+1", got, 32'h0000_007F);
    run_txn(1'b0, 3'b001, 32'h202, 32'h0, 0, 0, 32'h80FF_7F01, 0, got);
    chk("LH+2", got, 32'hFFFF_80FF);
    run_txn(1'b0, 3'b101, 32'h200, 32'h0, 0, 0, 32'h80FF_7F01, 0, got);
    chk("LHU+0", got, 32'h0000_7F01);

    // Misaligned
    run_txn(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 0, got);
    run_txn(1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0, 0, got);
    run_txn(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 0, got);

    // Slow bus: gnt after 5 cycles, rvalid 3 cycles after gnt
    run_txn(1'b0, 3'b010, 32'h800, 32'h0, 5, 2, 32'h1357_9BDF, 0, got);
    chk("slow_LW", got, 32'h1357_9BDF);

    // Hold in DONE for 3 cycles
    run_txn(1'b0, 3'b010, 32'h700, 32'h0, 0, 0, 32'h5A5A_A5A5, 3, got);
    chk("hold_LW", got, 32'h5A5A_A5A5);

    // Flush in REQ
    present(1'b1, 3'b010, 32'h400, 32'h1111_2222);
    @(negedge clk);
    chk("fr_issue_stall", 32'(stall), 32'd1);
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("fr_req", 32'(dbus_req), 32'd1);
    step();
    flush = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk("fr_req_drop", 32'(dbus_req), 32'd0);
    chk("fr_stall_drop", 32'(stall), 32'd0);
    step();

    // Flush in WAIT
    run_txn(1'b0, 3'b010, 32'h500, 32'h0, 0, 0, 32'h1122_3344, 0, got);
    present(1'b0, 3'b010, 32'h504, 32'h0);
    @(negedge clk);
    step();
    dbus_gnt = 1'b1;
    @(negedge clk);
    step();
    dbus_gnt = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("fw_wait_stall", 32'(stall), 32'd1);
    step();
    flush = 1'b0;
    valid = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 32'hAAAA_5555;
    @(negedge clk);
    chk("fw_await_rvalid", 32'(stall), 32'd1);
    step();
    dbus_rvalid = 1'b0;
    // Must be IDLE (not DONE): the next store starts immediately.
    run_txn(1'b1, 3'b001, 32'h602, 32'hBEEF_CAFE, 0, 0, 32'h0, 0, got);
    chk("fw_rdata_kept", rdata, 32'h1122_3344);

    // Reset while in WAIT
    present(1'b0, 3'b010, 32'h300, 32'h0);
    @(negedge clk);
    step();
    dbus_gnt = 1'b1;
    @(negedge clk);
    step();
    dbus_gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_wait_stall", 32'(stall), 32'd1);
    step();
    rst_n = 1'b1;
    valid = 1'b0;
    last_rd = '0;
    @(negedge clk);
    chk("rw_idle_stall", 32'(stall), 32'd0);
    chk("rw_idle_req", 32'(dbus_req), 32'd0);
    chk("rw_rdata0", rdata, 32'd0);
    step();
    dbus_rvalid = 1'b1;
    dbus_rdata = 32'h1234_5678;
    step();
    dbus_rvalid = 1'b0;
    @(negedge clk);
    chk("rw_late_rvalid", rdata, 32'd0);
    step();

    // Randomized accesses against the reference model
    for (int unsigned t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = we ? 3'b010 : 3'b100;
        4: f3 = we ? 3'b000 : 3'b101;
        5: f3 = 3'b011;
        6: f3 = 3'b110;
        default: f3 = 3'b111;
      endcase
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(f3) - 1);
      run_txn(we, f3, a, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom(), $urandom_range(0, 2), got);
    end

    // Timeout with TIMEOUT=4 instance
    do_reset();
    run_txn(1'b0, 3'b010, 32'h200, 32'h0, 0, 0, 32'hCAFE_F00D, 0, got);
    chk("to_pre_rdata", rdata_t, 32'hCAFE_F00D);
    present(1'b0, 3'b010, 32'h204, 32'h0);
    @(negedge clk);
    chk("to_issue_stall", 32'(stall_t), 32'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("to_req", 32'(dbus_req_t), 32'd1);
      chk("to_no_err_yet", 32'(bus_err_t), 32'd0);
    end
    step();
    @(negedge clk);
    chk("to_err", 32'(bus_err_t), 32'd1);
    chk("to_done_stall", 32'(stall_t), 32'd0);
    chk("to_done_req", 32'(dbus_req_t), 32'd0);
    chk("to_rdata0", rdata_t, 32'd0);
    step();
    valid = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("to_err_pulse", 32'(bus_err_t), 32'd0);
    step();
    dbus_rvalid = 1'b0;
    @(negedge clk);
    chk("to_stray_rvalid", rdata_t, 32'd0);
    step();
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
